// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_pkg
//  Description : Shared types and constants for the PC / fetch sequencer.
//                State encoding, default reset PC, alignment mask and an
//                alignment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [1:0]  ALIGN_MASK       = 2'b11;

    // Instruction addresses must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] & ALIGN_MASK) != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_timer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_timer
//  Description : Saturating cycle counter bounding one imem transaction.
//                expired is high during the LIMIT-th enabled cycle since the
//                last clear, so a capture in that same cycle can still win.
//  Ports       : clk, reset_n (async active-low), clr (sync clear),
//                en (count this cycle), expired (limit cycle reached)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_timer
    import pc_fetch_pkg::*;
#(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int             W    = $clog2(LIMIT + 1);
    localparam logic [W-1:0]   LAST = W'(LIMIT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of enabled cycles already completed.
    assign expired = en && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/pc_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_seq
//  Description : Owns the architectural PC and sequences one instruction fetch
//                per instruction (imem req/gnt/rvalid), hands the word to
//                decode over valid/ready and loads the PC from the NPC result
//                on accept. Stops on halt request, misaligned NPC or imem
//                timeout; only reset leaves HALT.
//  Ports       : clk, reset_n        clock / async active-low reset
//                pc, npc_in          current PC / NPC result for that PC
//                imem_req/addr/gnt/rvalid/rdata   instruction memory port
//                instr_valid/instr/instr_pc/instr_ready   decode handshake
//                halt_req, halted    stop request / halted status
//                err_misalign, err_timeout   sticky error flags
//                retire_cnt          accepted-instruction count
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_seq
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEFAULT,
    parameter int          FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] pc,
    input  logic [31:0] npc_in,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        halt_req,
    output logic        halted,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic [31:0] retire_cnt
);

    state_t state;
    logic   halt_pend;
    logic   timer_en;
    logic   timer_clr;
    logic   timer_expired;

    // imem_req is a register reset to 0, so the FETCH state right after reset
    // release is idle for one cycle; gating on imem_req keeps that cycle from
    // accepting a grant or consuming timer budget.
    assign timer_en  = ((state == ST_FETCH) && imem_req) || (state == ST_WAIT);
    assign timer_clr = (state == ST_ISSUE);
    assign imem_addr = pc;

    fetch_timer #(
        .LIMIT (FETCH_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_FETCH;
            pc           <= RESET_PC;
            instr        <= '0;
            instr_pc     <= '0;
            instr_valid  <= 1'b0;
            imem_req     <= 1'b0;
            halted       <= 1'b0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            retire_cnt   <= '0;
            halt_pend    <= 1'b0;
        end else begin
            if (halt_req && (state != ST_HALT)) begin
                halt_pend <= 1'b1;
            end
            case (state)
                ST_FETCH: begin
                    if (imem_req && imem_gnt) begin
                        imem_req <= 1'b0;
                        if (imem_rvalid) begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            state       <= ST_ISSUE;
                        end else if (timer_expired) begin
                            err_timeout <= 1'b1;
                            halted      <= 1'b1;
                            state       <= ST_HALT;
                        end else begin
                            state       <= ST_WAIT;
                        end
                    end else if (timer_expired) begin
                        imem_req    <= 1'b0;
                        err_timeout <= 1'b1;
                        halted      <= 1'b1;
                        state       <= ST_HALT;
                    end else begin
                        // Also raises the first request after reset release.
                        imem_req <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        state       <= ST_ISSUE;
                    end else if (timer_expired) begin
                        err_timeout <= 1'b1;
                        halted      <= 1'b1;
                        state       <= ST_HALT;
                    end
                end
                ST_ISSUE: begin
                    if (instr_valid && instr_ready) begin
                        instr_valid <= 1'b0;
                        retire_cnt  <= retire_cnt + 32'd1;
                        if (is_misaligned(npc_in)) begin
                            err_misalign <= 1'b1;
                            halted       <= 1'b1;
                            state        <= ST_HALT;
                        end else begin
                            pc <= npc_in;
                            if (halt_req || halt_pend) begin
                                halted <= 1'b1;
                                state  <= ST_HALT;
                            end else begin
                                imem_req <= 1'b1;
                                state    <= ST_FETCH;
                            end
                        end
                    end
                end
                default: begin
                    // HALT: everything frozen until reset.
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    halted      <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_seq
//  Description : Directed self-checking bench for pc_fetch_seq. Inputs are
//                driven and outputs sampled 1 time unit after each rising
//                clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_seq;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc;
    logic [31:0] npc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        halt_req;
    logic        halted;
    logic        err_misalign;
    logic        err_timeout;
    logic [31:0] retire_cnt;

    int vectors;
    int miscompares;

    pc_fetch_seq #(
        .RESET_PC      (32'h0000_3000),
        .FETCH_TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc           (pc),
        .npc_in       (npc_in),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .halt_req     (halt_req),
        .halted       (halted),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout),
        .retire_cnt   (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        npc_in      = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        halt_req    = 1'b0;
        steps(2);
        reset_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // ---------------- 1: reset state and zero-wait fetch ----------------
        do_reset();
        chk("rst_pc",        pc,                 32'h0000_3000);
        chk("rst_req",       32'(imem_req),      32'd0);
        chk("rst_valid",     32'(instr_valid),   32'd0);
        chk("rst_instr",     instr,              32'd0);
        chk("rst_instr_pc",  instr_pc,           32'd0);
        chk("rst_halted",    32'(halted),        32'd0);
        chk("rst_errs",      32'({err_misalign, err_timeout}), 32'd0);
        chk("rst_retire",    retire_cnt,         32'd0);
        step();
        chk("t1_req",        32'(imem_req),      32'd1);
        chk("t1_addr",       imem_addr,          32'h0000_3000);
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3C01_1234;
        instr_ready = 1'b1;
        npc_in      = 32'h0000_3004;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        chk("t1_valid",      32'(instr_valid),   32'd1);
        chk("t1_instr",      instr,              32'h3C01_1234);
        chk("t1_instr_pc",   instr_pc,           32'h0000_3000);
        chk("t1_req_issue",  32'(imem_req),      32'd0);
        step();
        chk("t1_pc",         pc,                 32'h0000_3004);
        chk("t1_retire",     retire_cnt,         32'd1);
        chk("t1_valid_drop", 32'(instr_valid),   32'd0);
        chk("t1_req_next",   32'(imem_req),      32'd1);
        chk("t1_addr_next",  imem_addr,          32'h0000_3004);

        // ---------------- 6: reset mid-WAIT, stray rvalid ----------------
        imem_gnt    = 1'b1;
        instr_ready = 1'b0;
        step();
        imem_gnt = 1'b0;
        chk("t6_wait_req",   32'(imem_req),      32'd0);
        reset_n = 1'b0;
        #1;
        chk("t6_async_pc",   pc,                 32'h0000_3000);
        chk("t6_async_ret",  retire_cnt,         32'd0);
        chk("t6_async_req",  32'(imem_req),      32'd0);
        step();
        reset_n     = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_2222;
        step();
        step();
        chk("t6_stray_val",  32'(instr_valid),   32'd0);
        chk("t6_req",        32'(imem_req),      32'd1);
        chk("t6_addr",       imem_addr,          32'h0000_3000);
        imem_gnt   = 1'b1;
        imem_rdata = 32'h0000_0013;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        chk("t6_instr",      instr,              32'h0000_0013);
        chk("t6_instr_pc",   instr_pc,           32'h0000_3000);

        // ---------------- 2: wait states and decode back-pressure ----------------
        do_reset();
        step();
        steps(3);
        chk("t2_req_held",   32'(imem_req),      32'd1);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hA5A5_0001;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        steps(4);
        chk("t2_valid",      32'(instr_valid),   32'd1);
        chk("t2_stable",     instr,              32'hA5A5_0001);
        chk("t2_no_retire",  retire_cnt,         32'd0);
        instr_ready = 1'b1;
        npc_in      = 32'h0000_3004;
        step();
        instr_ready = 1'b0;
        chk("t2_retire",     retire_cnt,         32'd1);
        chk("t2_pc",         pc,                 32'h0000_3004);
        chk("t2_no_err",     32'({err_misalign, err_timeout, halted}), 32'd0);

        // ---------------- 3: misaligned next PC ----------------
        do_reset();
        step();
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0067;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b1;
        npc_in      = 32'h0000_3006;
        step();
        instr_ready = 1'b0;
        chk("t3_err",        32'(err_misalign),  32'd1);
        chk("t3_halted",     32'(halted),        32'd1);
        chk("t3_pc",         pc,                 32'h0000_3000);
        chk("t3_retire",     retire_cnt,         32'd1);
        steps(5);
        chk("t3_req_off",    32'(imem_req),      32'd0);
        chk("t3_tmo_clr",    32'(err_timeout),   32'd0);

        // ---------------- 4a: grant never arrives ----------------
        do_reset();
        step();
        steps(14);
        chk("t4_pre_tmo",    32'({err_timeout, halted}), 32'd0);
        step();
        chk("t4_tmo",        32'(err_timeout),   32'd1);
        chk("t4_halted",     32'(halted),        32'd1);
        chk("t4_req_off",    32'(imem_req),      32'd0);
        chk("t4_mis_clr",    32'(err_misalign),  32'd0);

        // ---------------- 4b: capture on the limit cycle wins ----------------
        do_reset();
        step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        steps(13);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_0015;
        step();
        imem_rvalid = 1'b0;
        chk("t4b_valid",     32'(instr_valid),   32'd1);
        chk("t4b_instr",     instr,              32'hCAFE_0015);
        chk("t4b_no_err",    32'({err_timeout, halted}), 32'd0);

        // ---------------- 5: halt request during WAIT ----------------
        do_reset();
        step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        step();
        chk("t5_not_halt",   32'(halted),        32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0BAD_F00D;
        step();
        imem_rvalid = 1'b0;
        chk("t5_valid",      32'(instr_valid),   32'd1);
        instr_ready = 1'b1;
        npc_in      = 32'h0000_3004;
        step();
        instr_ready = 1'b0;
        chk("t5_halted",     32'(halted),        32'd1);
        chk("t5_pc",         pc,                 32'h0000_3004);
        chk("t5_retire",     retire_cnt,         32'd1);
        steps(4);
        chk("t5_req_off",    32'(imem_req),      32'd0);
        chk("t5_valid_off",  32'(instr_valid),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
